// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator and the word-organised data memory responder.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        resp_ready;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-port data memory behind a valid/ready request/response bus, with
// programmable wait states and byte-enable writes.
module dmrByteLane (
    input  logic [7:0] oldByte,
    input  logic [7:0] newByte,
    input  logic       en,
    output logic [7:0] mergedByte
);
    assign mergedByte = en ? newByte : oldByte;
endmodule

module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    // Any set address bit above the word-index field is out of range.
    localparam logic [31:0] RANGE_MASK = 32'(~((64'(DEPTH) << 2) - 64'd1));

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } memReq_t;

    state_t      state;
    logic [3:0]  waitCnt;
    memReq_t     lat;
    logic        reqReady;
    logic        respValid;
    logic        respErr;
    logic [31:0] respRdata;

    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    wordIdx;
    logic             accErr;
    logic             accessNow;
    logic             memWe;
    logic [3:0][7:0]  oldWord;
    logic [3:0][7:0]  mergedWord;

    assign wordIdx   = lat.addr[AW+1:2];
    assign accErr    = (lat.addr[1:0] != 2'b00) || ((lat.addr & RANGE_MASK) != 32'd0);
    assign accessNow = (state == WAIT) && (waitCnt == 4'd0);
    // A reset edge wins over a pending access so an aborted write never lands.
    assign memWe     = rst_n && accessNow && lat.write && !accErr;
    assign oldWord   = mem[wordIdx];

    generate
        for (genvar b = 0; b < 4; b++) begin : gLane
            dmrByteLane uLane (
                .oldByte    (oldWord[b]),
                .newByte    (lat.wdata[8*b +: 8]),
                .en         (lat.be[b]),
                .mergedByte (mergedWord[b])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (memWe)
            mem[wordIdx] <= mergedWord;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            waitCnt   <= 4'd0;
            respValid <= 1'b0;
            respRdata <= 32'd0;
            respErr   <= 1'b0;
            reqReady  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && reqReady) begin
                        lat.write <= bus.req_write;
                        lat.addr  <= bus.req_addr;
                        lat.wdata <= bus.req_wdata;
                        lat.be    <= bus.req_be;
                        waitCnt   <= 4'(WAIT_CYCLES);
                        reqReady  <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (waitCnt != 4'd0) begin
                        waitCnt <= waitCnt - 4'd1;
                    end else begin
                        respValid <= 1'b1;
                        respErr   <= accErr;
                        respRdata <= (accErr || lat.write) ? 32'd0 : oldWord;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    // Ready comes back one cycle after consumption, never on the same edge.
                    if (bus.resp_ready) begin
                        respValid <= 1'b0;
                        respRdata <= 32'd0;
                        respErr   <= 1'b0;
                        reqReady  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = reqReady;
    assign bus.resp_valid = respValid;
    assign bus.resp_rdata = respRdata;
    assign bus.resp_err   = respErr;
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words (power of two, >=2).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning extra access wait states (0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  write data.
REQ-010 SHALL have port req_be  input  4  byte enables; bit0 = bits 7:0 (little-endian).
REQ-011 SHALL have port resp_valid  output  1  response available.
REQ-012 SHALL have port resp_rdata  output  32  read data.
REQ-013 SHALL have port resp_err  output  1  request rejected (misaligned or out of range).
REQ-014 SHALL have port resp_ready  input  1  initiator accepts the response.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; 0 in WAIT and RESP.
REQ-017 SHALL accept a request on an edge where req_valid=1 and req_ready=1, latching write, addr, wdata, be, then go IDLE->WAIT with wait counter = WAIT_CYCLES.
REQ-018 SHALL, in WAIT, decrement the counter each edge while nonzero; on the edge it is 0, perform the access and go WAIT->RESP.
REQ-019 SHALL give latency: acceptance at edge N -> resp_valid=1 after edge N+1+WAIT_CYCLES (WAIT_CYCLES=0 -> after edge N+1).
REQ-020 SHALL compute word index = addr[log2(DEPTH)+1:2].
REQ-021 SHALL flag error when addr[1:0]!=0 or any addr bit above log2(DEPTH)+1 is 1; errored requests SHALL NOT modify memory, and SHALL return resp_err=1, resp_rdata=0.
REQ-022 SHALL on valid read return the addressed word on resp_rdata, resp_err=0.
REQ-023 SHALL on valid write update only bytes whose be bit is 1, return resp_rdata=0, resp_err=0; be=4'b0000 completes with no memory change.
REQ-024 SHALL, in RESP, hold resp_valid, resp_rdata, resp_err stable until an edge with resp_ready=1; then go RESP->IDLE and drop resp_valid.
REQ-025 SHALL NOT accept a new request on the same edge a response is consumed; req_ready rises the cycle after.
REQ-026 SHALL ignore request input changes while not in IDLE (latched copy used).
REQ-027 SHALL perform a read following a write to the same word with the written data (no staleness).

Reset
REQ-028 SHALL, on edge with rst_n=0, set state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0; req_ready=1 from the next cycle with rst_n=1.
REQ-029 SHALL NOT reset memory contents.
REQ-030 SHALL abort a request in WAIT on reset with no memory write; a response pending in RESP is discarded.

Verification
REQ-031 Write 0xDEADBEEF to 0x10, be=1111, then read 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0; resp_valid 3 cycles after each acceptance (WAIT_CYCLES=2).
REQ-032 Word 0x20 holds 0x11223344; write 0xAABBCCDD with be=0101 -> read returns 0x11BB33DD.
REQ-033 Read addr 0x02 -> resp_err=1, rdata=0; read addr 0x400 (DEPTH=256) -> resp_err=1; memory unchanged.
REQ-034 resp_ready held 0 for 5 cycles -> resp_valid/rdata stable throughout, req_ready=0; req_ready=1 the cycle after resp_ready=1 handshake.
REQ-035 Write 0x12345678 to 0x30 (previously 0), rst_n=0 while in WAIT -> state IDLE, resp_valid=0; subsequent read of 0x30 returns 0.
REQ-036 Rerun REQ-031 with WAIT_CYCLES=0 -> resp_valid the cycle after acceptance.
